// File: rtl/mem_param_pkg.sv
// Shared types and default sizing for the mem_param RAM wrapper.
// Holds the clear-sweep FSM encoding and the default WIDTH/DEPTH/RD_LATENCY values.
package mem_param_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_t;

   localparam int DEF_WIDTH      = 32;
   localparam int DEF_DEPTH      = 512;
   localparam int DEF_RD_LATENCY = 2;

endpackage

// File: rtl/mem_param_array.sv
// Plain storage array: one write port and one registered read port, kept simple so it maps to block RAM.
// Read data appears one edge after rd_en and holds otherwise; no backpressure.
module mem_param_array
   import mem_param_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = $clog2(DEF_DEPTH)
) (
   input  logic             clock,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   // Non-blocking read of mem gives read-before-write on a same-address edge.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data_q <= mem[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/mem_param.sv
// Parameterised RAM with a post-reset zero sweep (busy), rden->q_valid latency RD_LATENCY, reads every cycle, no backpressure.
// Define MEM_PARAM_BYPASS_EN to forward same-edge same-address write data to the read result.
module mem_param
   import mem_param_pkg::*;
#(
   parameter int  WIDTH      = DEF_WIDTH,
   parameter int  DEPTH      = DEF_DEPTH,
   parameter int  RD_LATENCY = DEF_RD_LATENCY,
   localparam int AW         = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             aclr,
   input  logic [WIDTH-1:0] data,
   input  logic [AW-1:0]    wraddress,
   input  logic             wren,
   input  logic [AW-1:0]    rdaddress,
   input  logic             rden,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   output logic             busy
);

   localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   state_t        state_q, state_d;
   logic [AW-1:0] clr_addr_q, clr_addr_d;
   logic          busy_q, busy_d;

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      busy_d     = busy_q;
      case (state_q)
         CLEAR: begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == LAST_ADDR) begin
               state_d    = IDLE;
               clr_addr_d = '0;
               busy_d     = 1'b0;
            end
         end
         IDLE: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         state_q    <= CLEAR;
         clr_addr_q <= '0;
         busy_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         busy_q     <= busy_d;
      end
   end

   assign busy = busy_q;

   logic             idle, wr_in_range, rd_in_range, user_wr, rd_acc;
   logic             arr_wr_en, arr_rd_en;
   logic [AW-1:0]    arr_wr_addr;
   logic [WIDTH-1:0] arr_wr_data, arr_rd_data;

   assign idle        = (state_q == IDLE);
   assign wr_in_range = ({1'b0, wraddress} < DEPTH_W);
   assign rd_in_range = ({1'b0, rdaddress} < DEPTH_W);
   assign user_wr     = idle & wren & wr_in_range;
   assign rd_acc      = idle & rden;

   // The sweep owns the write port until it finishes.
   assign arr_wr_en   = ~idle | user_wr;
   assign arr_wr_addr = idle ? wraddress : clr_addr_q;
   assign arr_wr_data = idle ? data : '0;
   assign arr_rd_en   = rd_acc & rd_in_range;

   mem_param_array #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clock   (clock),
      .wr_en   (arr_wr_en),
      .wr_addr (arr_wr_addr),
      .wr_data (arr_wr_data),
      .rd_en   (arr_rd_en),
      .rd_addr (rdaddress),
      .rd_data (arr_rd_data)
   );

   // Stage-1 side info travels alongside the array's registered read; zero/bypass flags only change on an accepted read so q holds.
   logic             s1_vld_q, s1_vld_d;
   logic             s1_zero_q, s1_zero_d;
   logic [WIDTH-1:0] s1_data;

`ifdef MEM_PARAM_BYPASS_EN
   logic             s1_byp_q, s1_byp_d;
   logic [WIDTH-1:0] s1_bdat_q, s1_bdat_d;

   always_comb begin
      s1_byp_d  = s1_byp_q;
      s1_bdat_d = s1_bdat_q;
      if (rd_acc) begin
         s1_byp_d  = user_wr & (wraddress == rdaddress);
         s1_bdat_d = data;
      end
   end

   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         s1_byp_q  <= 1'b0;
         s1_bdat_q <= '0;
      end else begin
         s1_byp_q  <= s1_byp_d;
         s1_bdat_q <= s1_bdat_d;
      end
   end

   assign s1_data = s1_byp_q ? s1_bdat_q : (s1_zero_q ? '0 : arr_rd_data);
`else
   assign s1_data = s1_zero_q ? '0 : arr_rd_data;
`endif

   always_comb begin
      s1_vld_d  = rd_acc;
      s1_zero_d = s1_zero_q;
      if (rd_acc) begin
         s1_zero_d = ~rd_in_range;
      end
   end

   // zero flag resets high so q reads 0 before the first real read.
   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         s1_vld_q  <= 1'b0;
         s1_zero_q <= 1'b1;
      end else begin
         s1_vld_q  <= s1_vld_d;
         s1_zero_q <= s1_zero_d;
      end
   end

   if (RD_LATENCY == 1) begin : g_lat1
      assign q       = s1_data;
      assign q_valid = s1_vld_q;
   end else begin : g_lat2
      logic [WIDTH-1:0] out_q, out_d;
      logic             vld_q, vld_d;

      always_comb begin
         out_d = out_q;
         vld_d = s1_vld_q;
         if (s1_vld_q) begin
            out_d = s1_data;
         end
      end

      always_ff @(posedge clock or posedge aclr) begin
         if (aclr) begin
            out_q <= '0;
            vld_q <= 1'b0;
         end else begin
            out_q <= out_d;
            vld_q <= vld_d;
         end
      end

      assign q       = out_q;
      assign q_valid = vld_q;
   end

endmodule

// File: tb/tb_mem_param.sv
// Scoreboard bench for mem_param: a 16x512 latency-2 instance and a 48x300 latency-1 instance.
// Expected read results are queued with their due cycle when issued and checked as q_valid arrives.
`timescale 1ns/1ps
module tb_mem_param;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic        aclr0, we0, re0, qv0, busy0;
   logic [15:0] data0, q0;
   logic [8:0]  wa0, ra0;

   logic        aclr1, we1, re1, qv1, busy1;
   logic [47:0] data1, q1;
   logic [8:0]  wa1, ra1;

   mem_param #(.WIDTH(16), .DEPTH(512), .RD_LATENCY(2)) dut0 (
      .clock(clk), .aclr(aclr0), .data(data0), .wraddress(wa0), .wren(we0),
      .rdaddress(ra0), .rden(re0), .q(q0), .q_valid(qv0), .busy(busy0)
   );

   mem_param #(.WIDTH(48), .DEPTH(300), .RD_LATENCY(1)) dut1 (
      .clock(clk), .aclr(aclr1), .data(data1), .wraddress(wa1), .wren(we1),
      .rdaddress(ra1), .rden(re1), .q(q1), .q_valid(qv1), .busy(busy1)
   );

`ifdef MEM_PARAM_BYPASS_EN
   localparam logic [47:0] EXP_RDW = 48'h2222;
`else
   localparam logic [47:0] EXP_RDW = 48'h1111;
`endif

   typedef struct {
      logic [47:0] d;
      int          due;
   } exp_t;

   exp_t sb0[$];
   exp_t sb1[$];

   int cyc   = 0;
   int n_cmp = 0;
   int n_err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One stimulus cycle on instance w; a read pushes its expected value and due cycle.
   task automatic op(input int w, input logic we, input int wa, input logic [47:0] wd,
                     input logic re, input int ra, input logic [47:0] rexp);
      exp_t e;
      @(negedge clk);
      e.d = rexp;
      if (w == 0) begin
         we0 = we; wa0 = 9'(wa); data0 = wd[15:0]; re0 = re; ra0 = 9'(ra);
         e.due = cyc + 2;
         if (re) sb0.push_back(e);
      end else begin
         we1 = we; wa1 = 9'(wa); data1 = wd; re1 = re; ra1 = 9'(ra);
         e.due = cyc + 1;
         if (re) sb1.push_back(e);
      end
   endtask

   task automatic nop(input int w);
      op(w, 1'b0, 0, 48'h0, 1'b0, 0, 48'h0);
   endtask

   always @(negedge clk) begin : mon0
      exp_t e;
      if (qv0) begin
         if (sb0.size() == 0) begin
            chk("qv0_spurious", 64'(qv0), 64'd0);
         end else begin
            e = sb0.pop_front();
            chk("q0_data", 64'(q0), 64'(e.d));
            chk("q0_cycle", 64'(cyc), 64'(e.due));
         end
      end else if (sb0.size() != 0 && sb0[0].due <= cyc) begin
         void'(sb0.pop_front());
         chk("qv0_missing", 64'(qv0), 64'd1);
      end
   end

   always @(negedge clk) begin : mon1
      exp_t e;
      if (qv1) begin
         if (sb1.size() == 0) begin
            chk("qv1_spurious", 64'(qv1), 64'd0);
         end else begin
            e = sb1.pop_front();
            chk("q1_data", 64'(q1), 64'(e.d));
            chk("q1_cycle", 64'(cyc), 64'(e.due));
         end
      end else if (sb1.size() != 0 && sb1[0].due <= cyc) begin
         void'(sb1.pop_front());
         chk("qv1_missing", 64'(qv1), 64'd1);
      end
   end

   initial begin
      int n0, n1;
      aclr0 = 1'b1; we0 = 1'b0; re0 = 1'b0; wa0 = '0; ra0 = '0; data0 = '0;
      aclr1 = 1'b1; we1 = 1'b0; re1 = 1'b0; wa1 = '0; ra1 = '0; data1 = '0;
      repeat (3) @(negedge clk);
      chk("rst_q0", 64'(q0), 64'd0);
      chk("rst_qv0", 64'(qv0), 64'd0);
      chk("rst_busy0", 64'(busy0), 64'd1);
      chk("rst_q1", 64'(q1), 64'd0);
      chk("rst_busy1", 64'(busy1), 64'd1);

      // Release both; a write+read to address 5 lands 10 cycles in while busy.
      aclr0 = 1'b0; aclr1 = 1'b0;
      n0 = 0; n1 = 0;
      for (int i = 0; i < 3000 && (busy0 || busy1); i++) begin
         if (busy0) n0++;
         if (busy1) n1++;
         we0 = (n0 == 10); wa0 = 9'd5; data0 = 16'hBEEF;
         re0 = (n0 == 10); ra0 = 9'd5;
         @(negedge clk);
      end
      we0 = 1'b0; re0 = 1'b0;
      chk("busy0_cycles", 64'(n0), 64'd512);
      chk("busy1_cycles", 64'(n1), 64'd300);

      for (int a = 0; a < 31; a++) op(0, 1'b0, 0, 48'h0, 1'b1, a, 48'h0);
      op(0, 1'b0, 0, 48'h0, 1'b1, 5, 48'h0);
      op(0, 1'b1, 0, 48'h0234, 1'b0, 0, 48'h0);
      op(0, 1'b1, 1, 48'h1234, 1'b0, 0, 48'h0);
      op(0, 1'b1, 2, 48'h2234, 1'b0, 0, 48'h0);
      op(0, 1'b0, 0, 48'h0, 1'b1, 0, 48'h0234);
      op(0, 1'b0, 0, 48'h0, 1'b1, 1, 48'h1234);
      op(0, 1'b0, 0, 48'h0, 1'b1, 2, 48'h2234);
      op(0, 1'b1, 8, 48'h8888, 1'b1, 1, 48'h1234);
      op(0, 1'b0, 0, 48'h0, 1'b1, 8, 48'h8888);
      op(0, 1'b1, 7, 48'h1111, 1'b0, 0, 48'h0);
      op(0, 1'b1, 7, 48'h2222, 1'b1, 7, EXP_RDW);
      op(0, 1'b0, 0, 48'h0, 1'b1, 7, 48'h2222);
      nop(0);
      repeat (4) @(negedge clk);
      chk("q0_hold", 64'(q0), 64'h2222);
      chk("qv0_idle", 64'(qv0), 64'd0);

      // Read in flight, then a one-cycle reset: the pulse must never appear.
      @(negedge clk);
      re0 = 1'b1; ra0 = 9'd0;
      @(negedge clk);
      re0 = 1'b0; aclr0 = 1'b1;
      @(negedge clk);
      chk("rst2_q0", 64'(q0), 64'd0);
      chk("rst2_qv0", 64'(qv0), 64'd0);
      chk("rst2_busy0", 64'(busy0), 64'd1);
      aclr0 = 1'b0;
      n0 = 0;
      for (int i = 0; i < 3000 && busy0; i++) begin
         n0++;
         @(negedge clk);
      end
      chk("busy0_cycles_rst2", 64'(n0), 64'd512);
      op(0, 1'b0, 0, 48'h0, 1'b1, 0, 48'h0);
      op(0, 1'b0, 0, 48'h0, 1'b1, 7, 48'h0);
      nop(0);

      op(1, 1'b1, 0, 48'h0234, 1'b0, 0, 48'h0);
      op(1, 1'b1, 1, 48'h1234, 1'b0, 0, 48'h0);
      op(1, 1'b1, 2, 48'h2234, 1'b0, 0, 48'h0);
      op(1, 1'b1, 310, 48'hABCDEF012345, 1'b0, 0, 48'h0);
      op(1, 1'b0, 0, 48'h0, 1'b1, 0, 48'h0234);
      op(1, 1'b0, 0, 48'h0, 1'b1, 1, 48'h1234);
      op(1, 1'b0, 0, 48'h0, 1'b1, 2, 48'h2234);
      op(1, 1'b0, 0, 48'h0, 1'b1, 310, 48'h0);
      op(1, 1'b1, 310, 48'h5555, 1'b1, 310, 48'h0);
      op(1, 1'b0, 0, 48'h0, 1'b1, 299, 48'h0);
      op(1, 1'b1, 299, 48'hFFFF00001299, 1'b0, 0, 48'h0);
      op(1, 1'b0, 0, 48'h0, 1'b1, 299, 48'hFFFF00001299);
      op(1, 1'b0, 0, 48'h0, 1'b1, 511, 48'h0);
      op(1, 1'b0, 0, 48'h0, 1'b1, 1, 48'h1234);
      nop(1);
      repeat (3) @(negedge clk);
      chk("q1_hold", 64'(q1), 64'h1234);
      chk("qv1_idle", 64'(qv1), 64'd0);

      for (int i = 0; i < 20 && (sb0.size() != 0 || sb1.size() != 0); i++) @(negedge clk);
      chk("sb0_drained", 64'(sb0.size()), 64'd0);
      chk("sb1_drained", 64'(sb1.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_param.md
MEM_PARAM -- requirements
Module: mem_param

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits (1..128).
REQ-002 Parameter DEPTH, default 512, number of words (2..4096, need not be a power of two).
REQ-003 Parameter RD_LATENCY, default 2, rden-to-q_valid latency in cycles (1 or 2).
REQ-004 Constant AW SHALL equal $clog2(DEPTH) and SHALL size both address ports.
REQ-005 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 aclr  in  1  reset; asynchronous, active-high.
REQ-007 data  in  WIDTH  write data.
REQ-008 wraddress  in  AW  write address.
REQ-009 wren  in  1  write enable.
REQ-010 rdaddress  in  AW  read address.
REQ-011 rden  in  1  read request.
REQ-012 q  out  WIDTH  read data, registered.
REQ-013 q_valid  out  1  one-cycle pulse marking q as the result of a read.
REQ-014 busy  out  1  high while the post-reset clear sweep runs.

Function
REQ-015 The FSM SHALL have two states: CLEAR and IDLE.
REQ-016 In CLEAR, the block SHALL write 0 to clr_addr each cycle and increment clr_addr; at clr_addr==DEPTH-1 it SHALL move to IDLE.
REQ-017 busy SHALL be high for exactly DEPTH cycles after aclr deasserts, then low.
REQ-018 While busy==1, wren and rden SHALL be ignored; no user write SHALL land, and q_valid SHALL stay 0.
REQ-019 In IDLE with wren==1 and wraddress<DEPTH, data SHALL be stored at wraddress on that edge.
REQ-020 The block SHALL ignore a write with wraddress>=DEPTH; a read with rdaddress>=DEPTH SHALL return q=0 with q_valid asserted normally.
REQ-021 For a read sampled with rden==1 on edge N, q_valid SHALL be 1 and q SHALL be valid after edge N+RD_LATENCY-1 (latency 2: address register plus output register).
REQ-022 The block SHALL accept reads every cycle; results SHALL appear in issue order with no bubbles.
REQ-023 q SHALL hold its last value when q_valid==0.
REQ-024 If a read and a write to the same address occur on the same edge, the read SHALL return the data from before the write, unless MEM_PARAM_BYPASS_EN is defined (REQ-030).
REQ-025 Concurrent reads and writes to different addresses SHALL not interact.

Reset
REQ-026 While aclr is high: q=0, q_valid=0, busy=1, FSM=CLEAR, clr_addr=0, and the read pipeline SHALL be flushed.
REQ-027 An aclr assertion mid-sweep SHALL restart the sweep from address 0.
REQ-028 An aclr assertion mid-read SHALL discard in-flight reads; their q_valid pulses SHALL never appear.
REQ-029 Memory contents need not be reset directly; the clear sweep SHALL provide the zero state.

Configuration
REQ-030 With MEM_PARAM_BYPASS_EN defined, a same-address, same-edge read-during-write SHALL return the new data, forwarded through the read pipeline with unchanged latency.
REQ-031 Without MEM_PARAM_BYPASS_EN, the block SHALL contain no forwarding logic, and old data SHALL be returned.

Structure
REQ-032 Package mem_param_pkg SHALL hold the FSM state typedef (CLEAR, IDLE) and the default WIDTH, DEPTH and RD_LATENCY constants.
REQ-033 Sub-module mem_param_array SHALL hold the storage as a plain write-port plus registered-read-port array, so that it infers block RAM; the FSM, muxing, bypass and valid pipeline SHALL live in mem_param.

Verification (WIDTH=16, DEPTH=512, RD_LATENCY=2 unless stated)
REQ-034 Release aclr -> busy high for exactly 512 cycles; then read addresses 0..30 -> every q=0000 and 31 q_valid pulses.
REQ-035 Write 0234/1234/2234 to addresses 0/1/2, then read 0,1,2 back-to-back -> q_valid high 3 consecutive cycles, first pulse 2 edges after the first rden, q=0234,1234,2234 in order.
REQ-036 Write BEEF to address 5 at cycle 10 after reset release (busy=1) -> after busy falls, read 5 gives 0000.
REQ-037 Address 7 holds 1111; write 2222 to 7 and read 7 on the same edge -> q=1111 without MEM_PARAM_BYPASS_EN, 2222 with it.
REQ-038 Issue a read, pulse aclr for 1 cycle on the next cycle -> no q_valid pulse, q=0, busy high for 512 cycles; previously written 0234 at address 0 reads 0000.
REQ-039 Repeat REQ-035 with RD_LATENCY=1, DEPTH=300, WIDTH=48; add a write 0xABCDEF012345 to address 310 -> q_valid 1 edge after each rden; read 310 returns 0.
